// File: rtl/lcd_bus_pkg.sv
// rtl/lcd_bus_pkg.sv - LCD control-register layout, phases and word builder shared by master and slave
package lcd_bus_pkg;

    localparam int CS_BIT  = 28;
    localparam int RS_BIT  = 24;
    localparam int WR_BIT  = 20;
    localparam int RST_BIT = 16;

    localparam logic [31:0] LCD_CTRL_ADDR = 32'h41c0_0000;
    localparam logic [31:0] IDLE_WORD     = 32'h1111_0000;

    typedef enum logic [2:0] {
        PH_WRLO,
        PH_WRHI,
        PH_CSHI,
        PH_RSTLO,
        PH_RSTHI
    } phase_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP,
        ST_GAP,
        ST_RST_WAIT
    } state_e;

    // Reset phases carry no bus data; all others replay the latched word.
    function automatic logic [31:0] phase_word(input phase_e ph, input logic rs_val,
                                               input logic [15:0] data_val);
        logic        cs_b, rs_b, wr_b, rst_b;
        logic [15:0] d;
        logic [31:0] w;
        d = data_val;
        case (ph)
            PH_WRLO:  {cs_b, rs_b, wr_b, rst_b} = {1'b0, rs_val, 1'b0, 1'b1};
            PH_WRHI:  {cs_b, rs_b, wr_b, rst_b} = {1'b0, rs_val, 1'b1, 1'b1};
            PH_CSHI:  {cs_b, rs_b, wr_b, rst_b} = 4'b1111;
            PH_RSTLO: begin
                {cs_b, rs_b, wr_b, rst_b} = 4'b1110;
                d = 16'h0000;
            end
            default: begin
                {cs_b, rs_b, wr_b, rst_b} = 4'b1111;
                d = 16'h0000;
            end
        endcase
        w          = 32'h0000_0000;
        w[CS_BIT]  = cs_b;
        w[RS_BIT]  = rs_b;
        w[WR_BIT]  = wr_b;
        w[RST_BIT] = rst_b;
        w[15:0]    = d;
        return w;
    endfunction

endpackage

// File: rtl/lcd_axil_wr_channel.sv
// rtl/lcd_axil_wr_channel.sv - single AXI-lite AW/W/B write with abort timeout
module lcd_axil_wr_channel
    import lcd_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        issued_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] awaddr_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    output logic [31:0] wdata_o,
    input  logic        bvalid_i,
    output logic        bready_o
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        aw_left, w_left, active;

    assign aw_left   = awvalid_q & ~awready_i;
    assign w_left    = wvalid_q & ~wready_i;
    assign active    = awvalid_q | wvalid_q | bready_q;
    assign issued_o  = (awvalid_q | wvalid_q) & ~aw_left & ~w_left;
    assign done_o    = bready_q & bvalid_i;
    assign timeout_o = active & (tmo_cnt_q == TMO_LAST) & ~done_o;

    always_comb begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        bready_d  = issued_o | (bready_q & ~bvalid_i);
        wdata_d   = wdata_q;
        tmo_cnt_d = active ? tmo_cnt_q + 8'd1 : tmo_cnt_q;
        if (start_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b0;
            wdata_d   = data_i;
            tmo_cnt_d = 8'd0;
        end else if (timeout_o) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            tmo_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            wdata_q   <= IDLE_WORD;
            tmo_cnt_q <= 8'd0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            wdata_q   <= wdata_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign awvalid_o = awvalid_q;
    assign awaddr_o  = addr_i;
    assign wvalid_o  = wvalid_q;
    assign wdata_o   = wdata_q;
    assign bready_o  = bready_q;

endmodule

// File: rtl/lcd_axil_master.sv
// rtl/lcd_axil_master.sv - phase FSM turning LCD command words into AXI-lite bit-bang writes
module lcd_axil_master
    import lcd_bus_pkg::*;
#(
    parameter logic [31:0] TARGET_ADDR = LCD_CTRL_ADDR,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned RST_LOW_CYC = 1000,
    parameter int unsigned RST_REL_CYC = 1000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        aclk,
    input  logic        aresetn,
    output logic        maxi_AWVALID,
    input  logic        maxi_AWREADY,
    output logic [31:0] maxi_AWADDR,
    output logic        maxi_WVALID,
    input  logic        maxi_WREADY,
    output logic [31:0] maxi_WDATA,
    input  logic        maxi_BVALID,
    output logic        maxi_BREADY,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rs,
    input  logic [15:0] cmd_data,
    input  logic        cmd_last,
    input  logic        rst_req,
    input  logic        err_clr,
    output logic        busy,
    output logic        err
);

    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYC - 1);
    localparam logic [15:0] LOW_LOAD = 16'(RST_LOW_CYC - 1);
    localparam logic [15:0] REL_LOAD = 16'(RST_REL_CYC - 1);

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic        rs_q, rs_d;
    logic [15:0] data_q, data_d;
    logic        last_q, last_d;
    logic [15:0] wait_q, wait_d;
    logic        err_q, err_d;

    logic        ch_start, ch_issued, ch_done, ch_timeout;
    logic [31:0] ch_word;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rs_d    = rs_q;
        data_d  = data_q;
        last_d  = last_q;
        wait_d  = wait_q;
        err_d   = err_q & ~err_clr;
        case (state_q)
            ST_IDLE: begin
                if (rst_req) begin
                    phase_d = PH_RSTLO;
                    state_d = ST_ISSUE;
                end else if (cmd_valid) begin
                    rs_d    = cmd_rs;
                    data_d  = cmd_data;
                    last_d  = cmd_last;
                    phase_d = PH_WRLO;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ch_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (ch_issued) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (ch_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (ch_done) begin
                    case (phase_q)
                        PH_WRLO: begin
                            if (GAP_CYC == 0) begin
                                phase_d = PH_WRHI;
                                state_d = ST_ISSUE;
                            end else begin
                                wait_d  = GAP_LOAD;
                                state_d = ST_GAP;
                            end
                        end
                        // Without last, cs stays low so the next word continues the burst.
                        PH_WRHI: begin
                            if (last_q) begin
                                phase_d = PH_CSHI;
                                state_d = ST_ISSUE;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        PH_RSTLO: begin
                            if (RST_LOW_CYC == 0) begin
                                phase_d = PH_RSTHI;
                                state_d = ST_ISSUE;
                            end else begin
                                wait_d  = LOW_LOAD;
                                state_d = ST_RST_WAIT;
                            end
                        end
                        PH_RSTHI: begin
                            if (RST_REL_CYC == 0) begin
                                state_d = ST_IDLE;
                            end else begin
                                wait_d  = REL_LOAD;
                                state_d = ST_RST_WAIT;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_GAP: begin
                if (wait_q == 16'd0) begin
                    phase_d = PH_WRHI;
                    state_d = ST_ISSUE;
                end else begin
                    wait_d = wait_q - 16'd1;
                end
            end
            ST_RST_WAIT: begin
                if (wait_q != 16'd0) begin
                    wait_d = wait_q - 16'd1;
                end else if (phase_q == PH_RSTLO) begin
                    phase_d = PH_RSTHI;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A write is launched on every entry into ISSUE, using the word of the phase being entered.
    assign ch_start = (state_d == ST_ISSUE) && (state_q != ST_ISSUE);
    assign ch_word  = phase_word(phase_d, rs_d, data_d);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            phase_q <= PH_CSHI;
            rs_q    <= 1'b0;
            data_q  <= 16'h0000;
            last_q  <= 1'b0;
            wait_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    lcd_axil_wr_channel #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wr_channel (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start_i   (ch_start),
        .addr_i    (TARGET_ADDR),
        .data_i    (ch_word),
        .issued_o  (ch_issued),
        .done_o    (ch_done),
        .timeout_o (ch_timeout),
        .awvalid_o (maxi_AWVALID),
        .awready_i (maxi_AWREADY),
        .awaddr_o  (maxi_AWADDR),
        .wvalid_o  (maxi_WVALID),
        .wready_i  (maxi_WREADY),
        .wdata_o   (maxi_WDATA),
        .bvalid_i  (maxi_BVALID),
        .bready_o  (maxi_BREADY)
    );

    assign cmd_ready = (state_q == ST_IDLE) & ~rst_req;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_lcd_axil_master.sv
// tb/tb_lcd_axil_master.sv - directed self-checking bench for lcd_axil_master
module tb_lcd_axil_master;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        maxi_AWVALID, maxi_WVALID, maxi_BREADY;
    logic        maxi_AWREADY = 1'b0, maxi_WREADY = 1'b0, maxi_BVALID = 1'b0;
    logic [31:0] maxi_AWADDR, maxi_WDATA;
    logic        cmd_valid = 1'b0, cmd_rs = 1'b0, cmd_last = 1'b0;
    logic [15:0] cmd_data = 16'h0000;
    logic        cmd_ready, rst_req = 1'b0, err_clr = 1'b0, busy, err;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_log[$];
    int   aw_cnt = 0, b_cnt = 0, aw_age = 0;
    int   w_delay = 0;
    int   clear_req = 0, clear_seen = 0;
    logic aw_hs = 1'b0, w_hs = 1'b0, b_en = 1'b1;

    always #5 aclk = ~aclk;

    lcd_axil_master #(
        .GAP_CYC     (2),
        .RST_LOW_CYC (10),
        .RST_REL_CYC (20),
        .TIMEOUT_CYC (255)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .maxi_AWVALID (maxi_AWVALID),
        .maxi_AWREADY (maxi_AWREADY),
        .maxi_AWADDR  (maxi_AWADDR),
        .maxi_WVALID  (maxi_WVALID),
        .maxi_WREADY  (maxi_WREADY),
        .maxi_WDATA   (maxi_WDATA),
        .maxi_BVALID  (maxi_BVALID),
        .maxi_BREADY  (maxi_BREADY),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rs       (cmd_rs),
        .cmd_data     (cmd_data),
        .cmd_last     (cmd_last),
        .rst_req      (rst_req),
        .err_clr      (err_clr),
        .busy         (busy),
        .err          (err)
    );

    // Slave model: handshakes observed on the rising edge, responses driven on the falling edge.
    always @(posedge aclk) begin
        if (clear_req != clear_seen) begin
            aw_hs = 1'b0;
            w_hs = 1'b0;
            clear_seen = clear_req;
        end
        if (maxi_AWVALID && maxi_AWREADY) begin
            aw_hs = 1'b1;
            aw_age = 0;
            aw_cnt++;
        end else if (aw_hs) begin
            aw_age++;
        end
        if (maxi_WVALID && maxi_WREADY) begin
            w_hs = 1'b1;
            wr_log.push_back(maxi_WDATA);
        end
        if (maxi_BVALID && maxi_BREADY) begin
            b_cnt++;
            aw_hs = 1'b0;
            w_hs = 1'b0;
        end
    end

    always @(negedge aclk) begin
        maxi_AWREADY = 1'b1;
        maxi_WREADY  = (w_delay == 0) ? 1'b1 : (aw_hs && (aw_age >= w_delay));
        maxi_BVALID  = b_en && aw_hs && w_hs;
    end

    function automatic logic [31:0] log_at(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic send_cmd(input logic rs, input logic [15:0] d, input logic l);
        int n = 0;
        @(negedge aclk);
        cmd_valid = 1'b1;
        cmd_rs    = rs;
        cmd_data  = d;
        cmd_last  = l;
        while (!cmd_ready && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        checks++;
        if ({maxi_AWVALID, maxi_WVALID, maxi_BREADY, busy, err, cmd_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags: aw,w,b,busy,err,rdy=%b required 000001",
                     {maxi_AWVALID, maxi_WVALID, maxi_BREADY, busy, err, cmd_ready});
        end
        checks++;
        if (maxi_WDATA !== 32'h1111_0000) begin
            errors++;
            $display("FAIL reset_wdata: %h required 11110000", maxi_WDATA);
        end
        checks++;
        if (maxi_AWADDR !== 32'h41c0_0000) begin
            errors++;
            $display("FAIL reset_awaddr: %h required 41c00000", maxi_AWADDR);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_single_word();
        logic [31:0] exp [2] = '{32'h0001_002C, 32'h0011_002C};
        int b0 = b_cnt;
        wr_log.delete();
        send_cmd(1'b0, 16'h002C, 1'b0);
        wait_idle(100);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (log_at(i) !== exp[i]) begin
                errors++;
                $display("FAIL single_word[%0d]: wdata %h required %h", i, log_at(i), exp[i]);
            end
        end
        checks++;
        if (wr_log.size() != 2 || b_cnt - b0 != 2) begin
            errors++;
            $display("FAIL single_count: writes %0d b %0d required 2 2", wr_log.size(), b_cnt - b0);
        end
        checks++;
        if (maxi_WDATA[28] !== 1'b0) begin
            errors++;
            $display("FAIL single_cs_low: cs=%b required 0", maxi_WDATA[28]);
        end
    endtask

    task automatic test_last_word();
        logic [31:0] exp [3] = '{32'h0001_002C, 32'h0011_002C, 32'h1111_002C};
        int b0 = b_cnt;
        wr_log.delete();
        send_cmd(1'b0, 16'h002C, 1'b1);
        wait_idle(100);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_at(i) !== exp[i]) begin
                errors++;
                $display("FAIL last_word[%0d]: wdata %h required %h", i, log_at(i), exp[i]);
            end
        end
        checks++;
        if (wr_log.size() != 3 || b_cnt - b0 != 3) begin
            errors++;
            $display("FAIL last_count: writes %0d b %0d required 3 3", wr_log.size(), b_cnt - b0);
        end
    endtask

    task automatic test_w_delay();
        logic [31:0] exp [2] = '{32'h0101_5A5A, 32'h0111_5A5A};
        int b0 = b_cnt;
        int a0 = aw_cnt;
        int split = 0;
        int n = 0;
        wr_log.delete();
        w_delay = 3;
        send_cmd(1'b1, 16'h5A5A, 1'b0);
        while (busy && n < 200) begin
            if (!maxi_AWVALID && maxi_WVALID) split++;
            @(negedge aclk);
            n++;
        end
        w_delay = 0;
        checks++;
        if (split != 8) begin
            errors++;
            $display("FAIL wdelay_split: w-only cycles %0d required 8", split);
        end
        checks++;
        if (aw_cnt - a0 != 2 || b_cnt - b0 != 2) begin
            errors++;
            $display("FAIL wdelay_count: aw %0d b %0d required 2 2", aw_cnt - a0, b_cnt - b0);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (log_at(i) !== exp[i]) begin
                errors++;
                $display("FAIL wdelay_word[%0d]: wdata %h required %h", i, log_at(i), exp[i]);
            end
        end
    endtask

    task automatic test_rst_seq();
        logic [31:0] exp [2] = '{32'h1110_0000, 32'h1111_0000};
        int b0 = b_cnt;
        int lo_idle = 0;
        int rel_wait = 0;
        int n = 0;
        wr_log.delete();
        @(negedge aclk);
        rst_req   = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = 16'hFFFF;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: cmd_ready=%b required 0", cmd_ready);
        end
        @(negedge aclk);
        rst_req   = 1'b0;
        cmd_valid = 1'b0;
        while (busy && n < 300) begin
            if (b_cnt - b0 == 1 && !maxi_AWVALID && !maxi_WVALID && !maxi_BREADY) lo_idle++;
            if (b_cnt - b0 == 2 && !cmd_ready) rel_wait++;
            @(negedge aclk);
            n++;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (log_at(i) !== exp[i]) begin
                errors++;
                $display("FAIL rst_word[%0d]: wdata %h required %h", i, log_at(i), exp[i]);
            end
        end
        checks++;
        if (lo_idle != 10) begin
            errors++;
            $display("FAIL rst_low_gap: idle cycles %0d required 10", lo_idle);
        end
        checks++;
        if (rel_wait != 20) begin
            errors++;
            $display("FAIL rst_release: cmd_ready-low cycles %0d required 20", rel_wait);
        end
        checks++;
        if (wr_log.size() != 2 || b_cnt - b0 != 2 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_count: writes %0d b %0d rdy %b required 2 2 1",
                     wr_log.size(), b_cnt - b0, cmd_ready);
        end
    endtask

    task automatic test_timeout();
        int act = 0;
        int n = 0;
        wr_log.delete();
        b_en = 1'b0;
        send_cmd(1'b0, 16'h0077, 1'b0);
        while (busy && n < 600) begin
            if (maxi_AWVALID || maxi_WVALID || maxi_BREADY) act++;
            @(negedge aclk);
            n++;
        end
        clear_req++;
        b_en = 1'b1;
        checks++;
        if (act != 255) begin
            errors++;
            $display("FAIL timeout_len: active cycles %0d required 255", act);
        end
        checks++;
        if ({err, maxi_BREADY, busy} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_state: err,bready,busy=%b required 100", {err, maxi_BREADY, busy});
        end
        repeat (3) @(negedge aclk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b required 1", err);
        end
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: err=%b required 0", err);
        end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] exp [2] = '{32'h0001_0042, 32'h0011_0042};
        int n = 0;
        int b0;
        b_en = 1'b0;
        send_cmd(1'b1, 16'h00AA, 1'b1);
        while (!maxi_BREADY && n < 50) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (maxi_BREADY !== 1'b1) begin
            errors++;
            $display("FAIL resp_reach: bready=%b required 1", maxi_BREADY);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({maxi_AWVALID, maxi_WVALID, maxi_BREADY, busy, err} !== 5'b00000) begin
            errors++;
            $display("FAIL async_reset_flags: aw,w,b,busy,err=%b required 00000",
                     {maxi_AWVALID, maxi_WVALID, maxi_BREADY, busy, err});
        end
        checks++;
        if (maxi_WDATA !== 32'h1111_0000) begin
            errors++;
            $display("FAIL async_reset_wdata: %h required 11110000", maxi_WDATA);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        clear_req++;
        b_en = 1'b1;
        wr_log.delete();
        b0 = b_cnt;
        send_cmd(1'b0, 16'h0042, 1'b0);
        wait_idle(100);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (log_at(i) !== exp[i]) begin
                errors++;
                $display("FAIL post_reset[%0d]: wdata %h required %h", i, log_at(i), exp[i]);
            end
        end
        checks++;
        if (b_cnt - b0 != 2) begin
            errors++;
            $display("FAIL post_reset_b: b %0d required 2", b_cnt - b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [5] = '{32'h0101_A5A5, 32'h0111_A5A5,
                                 32'h0001_1234, 32'h0011_1234, 32'h1111_1234};
        int b0 = b_cnt;
        wr_log.delete();
        send_cmd(1'b1, 16'hA5A5, 1'b0);
        send_cmd(1'b0, 16'h1234, 1'b1);
        wait_idle(100);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_at(i) !== exp[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: wdata %h required %h", i, log_at(i), exp[i]);
            end
        end
        checks++;
        if (wr_log.size() != 5 || b_cnt - b0 != 5) begin
            errors++;
            $display("FAIL b2b_count: writes %0d b %0d required 5 5", wr_log.size(), b_cnt - b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_last_word();
        test_w_delay();
        test_rst_seq();
        test_timeout();
        test_reset_in_resp();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
